// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache (8 lines x 4 bytes) with its miss-handling FSM.
// Hits are serviced with no wait cycles; misses write back a dirty victim and then refill the line.
module dcache_controller (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t state, next_state;

  logic [7:0]  valid, dirty;
  logic [2:0]  tag_array  [8];
  logic [31:0] data_array [8];

  logic [5:0]  mem_address_q;
  logic [31:0] mem_writedata_q;

  logic [2:0]  tag, index;
  logic [1:0]  offset;
  logic [31:0] line_data;
  logic        hit, access, write_hit;

  assign tag       = ADDRESS[7:5];
  assign index     = ADDRESS[4:2];
  assign offset    = ADDRESS[1:0];
  assign line_data = data_array[index];
  assign hit       = valid[index] && (tag_array[index] == tag);
  assign access    = READ || WRITE;
  // A simultaneous READ and WRITE is handled as a store.
  assign write_hit = (state == IDLE) && WRITE && hit;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: defaulting every combinational output first keeps this block free of inferred latches.
    next_state = state;
    case (state)
      IDLE:      if (access && !hit) next_state = (valid[index] && dirty[index]) ? WRITEBACK : FETCH;
      WRITEBACK: if (!MEM_BUSYWAIT) next_state = FETCH;
      FETCH:     if (!MEM_BUSYWAIT) next_state = UPDATE;
      UPDATE:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = mem_address_q;
    MEM_WRITEDATA = mem_writedata_q;
    case (state)
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_array[index], index};
        MEM_WRITEDATA = line_data;
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = ADDRESS[7:2];
      end
      default: ;
    endcase
    BUSYWAIT = access && ((state != IDLE) || !hit);
    READDATA = (READ && hit && (state == IDLE)) ? line_data[{offset, 3'b000} +: 8] : 8'h00;
  end

  // The memory-side address and data keep their last driven value between transfers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_address_q   <= 6'h00;
      mem_writedata_q <= 32'h0;
    end else begin
      mem_address_q   <= MEM_ADDRESS;
      mem_writedata_q <= MEM_WRITEDATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid <= 8'h00;
      dirty <= 8'h00;
    end else if (state == UPDATE) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (write_hit) begin
      dirty[index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; cleared valid bits make their contents irrelevant.
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      data_array[index] <= MEM_READDATA;
      tag_array[index]  <= tag;
    end else if (write_hit) begin
      data_array[index][{offset, 3'b000} +: 8] <= WRITEDATA;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a latency-programmable block memory model, a vector table of CPU
// accesses with hand-derived results, and a scoreboard matching each access to what the DUT did.
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [7:0]  writedata = 8'h00;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_busywait;

  dcache_controller dut (
    .CLK(clk), .RESET(reset), .READ(read), .WRITE(write), .ADDRESS(address),
    .WRITEDATA(writedata), .READDATA(readdata), .BUSYWAIT(busywait),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEM_ADDRESS(mem_address),
    .MEM_WRITEDATA(mem_writedata), .MEM_READDATA(mem_rdata), .MEM_BUSYWAIT(mem_busywait)
  );

  always #5 clk = ~clk;

  // Memory model: busy for mem_lat cycles after a request appears, then completes on the next edge.
  logic [31:0] mem [64];
  int          mem_lat = 4;
  int          mem_cnt = 0;
  logic        mem_ready = 1'b0;

  assign mem_busywait = (mem_read || mem_write) && (mem_cnt != mem_lat);

  always @(posedge clk) begin
    if (!mem_ready) begin
      // Byte k of block i is {k, i}; a few blocks get distinctive contents.
      for (int i = 0; i < 64; i++)
        mem[i] <= {2'b11, 6'(i), 2'b10, 6'(i), 2'b01, 6'(i), 2'b00, 6'(i)};
      mem[1]  <= 32'hDDCCBBAA;
      mem[9]  <= 32'h44332211;
      mem[27] <= 32'h87654321;
      mem_ready <= 1'b1;
    end else if (mem_read || mem_write) begin
      if (mem_cnt == mem_lat) begin
        mem_cnt <= 0;
        if (mem_write) mem[mem_address] <= mem_writedata;
        if (mem_read)  mem_rdata <= mem[mem_address];
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    int          lat;
    logic        chk_rd;
    logic [7:0]  rdata;
    int          stalls;
    int          n_fetch;
    logic [5:0]  fetch_addr;
    int          n_wb;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
  } vec_t;

  typedef struct {
    logic [7:0]  rdata;
    int          stalls;
    int          n_fetch;
    logic [5:0]  fetch_addr;
    int          n_wb;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
  } obs_t;

  vec_t sb_q[$];
  vec_t tbl[13];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic rd, input logic wr, input logic [7:0] addr,
                               input logic [7:0] wdata, input int lat, input logic chk_rd,
                               input logic [7:0] rdata, input int stalls, input int n_fetch,
                               input logic [5:0] fetch_addr, input int n_wb,
                               input logic [5:0] wb_addr, input logic [31:0] wb_data);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.lat = lat;
    v.chk_rd = chk_rd; v.rdata = rdata; v.stalls = stalls;
    v.n_fetch = n_fetch; v.fetch_addr = fetch_addr;
    v.n_wb = n_wb; v.wb_addr = wb_addr; v.wb_data = wb_data;
    return v;
  endfunction

  // Drive one CPU access, observe it until BUSYWAIT falls, then score it against the queued record.
  task automatic run_vec(input vec_t v, input int id);
    vec_t e;
    obs_t o;
    bit   done;
    o = '{default: 0};
    done = 1'b0;
    @(posedge clk); #1;
    mem_lat = v.lat;
    read = v.rd; write = v.wr; address = v.addr; writedata = v.wdata;
    sb_q.push_back(v);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (mem_read) begin
        o.n_fetch++;
        o.fetch_addr = mem_address;
      end
      if (mem_write) begin
        o.n_wb++;
        o.wb_addr = mem_address;
        o.wb_data = mem_writedata;
      end
      if (!busywait) begin
        done = 1'b1;
        o.rdata = readdata;
      end else begin
        o.stalls++;
      end
    end
    check($sformatf("v%0d completes", id), 32'(done), 32'd1);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    e = sb_q.pop_front();
    check($sformatf("v%0d stall cycles", id), o.stalls, e.stalls);
    check($sformatf("v%0d fetch cycles", id), o.n_fetch, e.n_fetch);
    check($sformatf("v%0d writeback cycles", id), o.n_wb, e.n_wb);
    if (e.chk_rd)      check($sformatf("v%0d READDATA", id), 32'(o.rdata), 32'(e.rdata));
    if (e.n_fetch > 0) check($sformatf("v%0d fetch address", id), 32'(o.fetch_addr), 32'(e.fetch_addr));
    if (e.n_wb > 0) begin
      check($sformatf("v%0d writeback address", id), 32'(o.wb_addr), 32'(e.wb_addr));
      check($sformatf("v%0d writeback data", id), o.wb_data, e.wb_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    //              rd    wr    addr   wdata  lat chk   rdata  stall nf fadr   nw wadr   wdata
    tbl[0]  = mkv(1'b1, 1'b0, 8'h05, 8'h00, 4, 1'b1, 8'hBB,  7, 5, 6'h01, 0, 6'h00, 32'h0);
    tbl[1]  = mkv(1'b1, 1'b0, 8'h07, 8'h00, 4, 1'b1, 8'hDD,  0, 0, 6'h00, 0, 6'h00, 32'h0);
    tbl[2]  = mkv(1'b0, 1'b1, 8'h04, 8'h5A, 4, 1'b0, 8'h00,  0, 0, 6'h00, 0, 6'h00, 32'h0);
    tbl[3]  = mkv(1'b1, 1'b0, 8'h04, 8'h00, 4, 1'b1, 8'h5A,  0, 0, 6'h00, 0, 6'h00, 32'h0);
    tbl[4]  = mkv(1'b1, 1'b0, 8'h24, 8'h00, 4, 1'b1, 8'h11, 12, 5, 6'h09, 5, 6'h01, 32'hDDCCBB5A);
    tbl[5]  = mkv(1'b0, 1'b1, 8'h6D, 8'hC3, 4, 1'b0, 8'h00,  7, 5, 6'h1B, 0, 6'h00, 32'h0);
    tbl[6]  = mkv(1'b1, 1'b0, 8'h6D, 8'h00, 4, 1'b1, 8'hC3,  0, 0, 6'h00, 0, 6'h00, 32'h0);
    tbl[7]  = mkv(1'b1, 1'b0, 8'h0D, 8'h00, 4, 1'b1, 8'h43, 12, 5, 6'h03, 5, 6'h1B, 32'h8765C321);
    tbl[8]  = mkv(1'b1, 1'b0, 8'hFF, 8'h00, 0, 1'b1, 8'hFF,  3, 1, 6'h3F, 0, 6'h00, 32'h0);
    tbl[9]  = mkv(1'b1, 1'b1, 8'hFE, 8'h77, 0, 1'b0, 8'h00,  0, 0, 6'h00, 0, 6'h00, 32'h0);
    tbl[10] = mkv(1'b1, 1'b0, 8'hFE, 8'h00, 0, 1'b1, 8'h77,  0, 0, 6'h00, 0, 6'h00, 32'h0);
    tbl[11] = mkv(1'b1, 1'b0, 8'h1C, 8'h00, 2, 1'b1, 8'h07,  8, 3, 6'h07, 3, 6'h3F, 32'hFF777F3F);
    tbl[12] = mkv(1'b1, 1'b0, 8'hFE, 8'h00, 1, 1'b1, 8'h77,  4, 2, 6'h3F, 0, 6'h00, 32'h0);

    // Reset state while RESET is held low.
    #12;
    check("reset BUSYWAIT", 32'(busywait), 32'd0);
    check("reset MEM_READ", 32'(mem_read), 32'd0);
    check("reset MEM_WRITE", 32'(mem_write), 32'd0);
    check("reset MEM_ADDRESS", 32'(mem_address), 32'd0);
    check("reset MEM_WRITEDATA", mem_writedata, 32'd0);
    check("reset READDATA", 32'(readdata), 32'd0);
    @(negedge clk); reset = 1'b1;

    // Reset asserted in the middle of a refill aborts it at once.
    @(posedge clk); #1;
    mem_lat = 4; read = 1'b1; address = 8'h05;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = mem_read;
    end
    check("mid-fetch MEM_READ raised", 32'(seen), 32'd1);
    @(negedge clk);
    reset = 1'b0; #1;
    check("abort MEM_READ", 32'(mem_read), 32'd0);
    check("abort MEM_WRITE", 32'(mem_write), 32'd0);
    read = 1'b0; #1;
    check("abort BUSYWAIT idle", 32'(busywait), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;

    // Table: the first read of 0x05 must miss again, proving the aborted refill left no line behind.
    for (int i = 0; i < 13; i++) begin
      run_vec(tbl[i], i);
      if (i == 1) check("MEM_ADDRESS held after hit", 32'(mem_address), 32'h01);
      if (i == 4) check("MEM_WRITEDATA held after refill", mem_writedata, 32'hDDCCBB5A);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back data cache with its controller FSM, placed between the CPU data port and the word-wide data memory.
- Serves CPU byte loads and stores (lwd/lwi/swd/swi) in zero wait cycles on a hit.
- Sequences block write-back and block refill over the memory handshake on a miss, holding the CPU stalled through BUSYWAIT.

Parameters:
- None. Geometry is fixed: 8 lines x 4 bytes, 8-bit byte address, 32-bit memory block.

Ports:
CLK  input  1  system clock; all state updates on posedge
RESET  input  1  asynchronous, active-low reset
READ  input  1  CPU load request
WRITE  input  1  CPU store request
ADDRESS  input  8  CPU byte address: tag[7:5], index[4:2], offset[1:0]
WRITEDATA  input  8  CPU store byte
READDATA  output  8  CPU load byte
BUSYWAIT  output  1  CPU stall; CPU holds READ/WRITE/ADDRESS/WRITEDATA stable while high
MEM_READ  output  1  block read request to memory
MEM_WRITE  output  1  block write request to memory
MEM_ADDRESS  output  6  block address {tag,index}
MEM_WRITEDATA  output  32  block being written back
MEM_READDATA  input  32  block returned by memory
MEM_BUSYWAIT  input  1  memory busy; high from the cycle a request appears until data is ready

Behaviour:
- Storage per line: valid, dirty, tag[2:0], data[31:0]. Byte at offset k is data[8k+7:8k].
- hit = valid[index] & (tag[index] == ADDRESS[7:5]).
- READ and WRITE both high: treated as a write.
- Reset (RESET=0, async):
  - state=IDLE; all valid and dirty bits cleared.
  - MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0, BUSYWAIT=0.
  - Data and tag arrays need not be cleared.
  - Reset mid-operation aborts immediately: requests drop, no line is updated.
- READDATA: combinational selected byte of the indexed line; meaningful only when READ & hit & state==IDLE.
- BUSYWAIT: combinational = (READ|WRITE) & (state!=IDLE | !hit). Low whenever there is no request.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE:
  - Read hit: no state change; data returned in the same cycle.
  - Write hit: at posedge, write the byte into the line and set dirty=1.
  - Miss on clean or invalid line -> FETCH.
  - Miss on valid dirty line -> WRITEBACK.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=line data.
  - At the first posedge with MEM_BUSYWAIT=0 -> FETCH.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2].
  - At the first posedge with MEM_BUSYWAIT=0 -> UPDATE.
- UPDATE (exactly 1 cycle):
  - MEM_READ=0, MEM_WRITE=0.
  - At posedge, write MEM_READDATA, tag and valid=1, dirty=0 into the line -> IDLE.
- After UPDATE, the retried access hits in IDLE and is serviced as a hit; a retried store sets dirty then.
- Memory requests are driven only in WRITEBACK/FETCH and are 0 in every other state.
- MEM_ADDRESS and MEM_WRITEDATA hold their last value outside those states.
- The CPU request is sampled in IDLE only; it must not change while BUSYWAIT=1.
- Latency, with memory latency L = cycles MEM_BUSYWAIT stays high:
  - Hit: 0 extra cycles.
  - Clean miss: L+1 (FETCH) + 1 (UPDATE), then the hit cycle.
  - Dirty miss adds L+1 for WRITEBACK.
- The CPU must deassert its request after a posedge where BUSYWAIT=0; otherwise the access repeats, which is harmless because reads and writes are idempotent.

Test Plan:
- Reset: drive RESET=0 mid-FETCH with MEM_READ=1 -> MEM_READ drops at once; BUSYWAIT=0 with no request; a read of 0x05 after release misses.
- Clean read miss: READ, ADDRESS=0x05, memory returns 0xDDCCBBAA with L=4 -> MEM_READ=1 and MEM_ADDRESS=0x01 for 5 cycles, UPDATE 1 cycle, then READDATA=0xBB, BUSYWAIT=0, no MEM_WRITE.
- Read hit: after the previous test, READ 0x07 -> READDATA=0xDD with BUSYWAIT=0 in the same cycle, no memory request.
- Write hit: WRITE 0x04 data 0x5A -> BUSYWAIT=0, one cycle; a later READ 0x04 returns 0x5A; the line is dirty.
- Dirty eviction: after the write hit, READ 0x24 -> MEM_WRITE=1, MEM_ADDRESS=0x01, MEM_WRITEDATA=0xDDCCBB5A until MEM_BUSYWAIT falls; then MEM_READ=1 with MEM_ADDRESS=0x09; after UPDATE, READDATA = byte 0 of the new block.
- Write miss on clean line (index 3, ADDRESS=0x6D): FETCH with MEM_ADDRESS=0x1B, UPDATE, then byte 1 written -> a following READ 0x6D returns the stored byte and the line is dirty.
